// File: rtl/lcd_bus_sequencer_if.sv
// Request handshake and LCD pin bundle for lcd_bus_sequencer.
//   req_valid/req_rs/req_data : byte request from the content logic
//   req_ready/busy            : sequencer idle / not idle
//   RS/E/LCD_D                : HD44780 4-bit bus pins (LCD_D[3]=D7 .. LCD_D[0]=D4)
interface lcd_bus_sequencer_if;
   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;
   logic       busy;
   logic       RS;
   logic       E;
   logic [3:0] LCD_D;

   // Content generator side
   modport master (
      output req_valid, req_rs, req_data,
      input  req_ready, busy, RS, E, LCD_D
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_rs, req_data,
      output req_ready, busy, RS, E, LCD_D
   );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// HD44780 4-bit bus sequencer: runs the power-on 4-bit init, then writes one
// accepted byte at a time as two nibble strobes followed by an execution wait.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of lcd_bus_sequencer_if (request handshake + LCD pins)
module lcd_bus_sequencer #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned PULSE_CYC = 4,
   parameter int unsigned HOLD_CYC  = 2,
   parameter int unsigned EXEC_CYC  = 64,
   parameter int unsigned LONG_CYC  = 2048,
   parameter int unsigned INIT_CYC  = 16384,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               CLK,
   input  logic               RST,
   lcd_bus_sequencer_if.slave bus
);

   localparam logic [2:0] ST_INIT_WAIT = 3'd0;
   localparam logic [2:0] ST_SETUP     = 3'd1;
   localparam logic [2:0] ST_PULSE     = 3'd2;
   localparam logic [2:0] ST_HOLD      = 3'd3;
   localparam logic [2:0] ST_WAIT      = 3'd4;
   localparam logic [2:0] ST_IDLE      = 3'd5;

   // Counters load length-1 and count down to 0, so each phase lasts its parameter
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 32'd1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 32'd1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 32'd1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_CYC - 32'd1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_CYC - 32'd1);
   localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(INIT_CYC - 32'd1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;      // init nibble index
   logic             init_q, init_d;    // still in power-on init
   logic             lo_q, lo_d;        // low nibble of the byte in flight
   logic [7:0]       byte_q, byte_d;    // latched request byte
   logic             rs_q, rs_d;
   logic             e_q, e_d;
   logic [3:0]       lcd_q, lcd_d;
   logic             ready_q, ready_d;
   logic             busy_q;

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CNT_W'(1);
      idx_d   = idx_q;
      init_d  = init_q;
      lo_d    = lo_q;
      byte_d  = byte_q;
      rs_d    = rs_q;
      e_d     = e_q;
      lcd_d   = lcd_q;
      ready_d = ready_q;

      case (state_q)
         ST_INIT_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_SETUP;
               cnt_d   = LD_SETUP;
               rs_d    = 1'b0;
               lcd_d   = 4'h3;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = LD_PULSE;
               e_d     = 1'b1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = LD_HOLD;
               e_d     = 1'b0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               if (init_q) begin
                  // First two init nibbles need the long wait
                  state_d = ST_WAIT;
                  cnt_d   = idx_q[1] ? LD_EXEC : LD_LONG;
               end else if (!lo_q) begin
                  state_d = ST_SETUP;
                  cnt_d   = LD_SETUP;
                  lo_d    = 1'b1;
                  lcd_d   = byte_q[3:0];
               end else begin
                  // Clear/home (command 0x00-0x03) need the long wait
                  state_d = ST_WAIT;
                  cnt_d   = (!rs_q && byte_q[7:2] == 6'd0) ? LD_LONG : LD_EXEC;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (init_q && idx_q != 2'd3) begin
                  state_d = ST_SETUP;
                  cnt_d   = LD_SETUP;
                  idx_d   = idx_q + 2'd1;
                  lcd_d   = (idx_q == 2'd2) ? 4'h2 : 4'h3;
               end else begin
                  state_d = ST_IDLE;
                  init_d  = 1'b0;
                  ready_d = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            cnt_d = cnt_q;
            if (bus.req_valid) begin
               state_d = ST_SETUP;
               cnt_d   = LD_SETUP;
               lo_d    = 1'b0;
               byte_d  = bus.req_data;
               rs_d    = bus.req_rs;
               lcd_d   = bus.req_data[7:4];
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT_WAIT;
            cnt_d   = LD_INIT;
            e_d     = 1'b0;
            ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT_WAIT;
         cnt_q   <= LD_INIT;
         idx_q   <= 2'd0;
         init_q  <= 1'b1;
         lo_q    <= 1'b0;
         byte_q  <= 8'h00;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         lcd_q   <= 4'h0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         init_q  <= init_d;
         lo_q    <= lo_d;
         byte_q  <= byte_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         lcd_q   <= lcd_d;
         ready_q <= ready_d;
         busy_q  <= ~ready_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.RS        = rs_q;
   assign bus.E         = e_q;
   assign bus.LCD_D     = lcd_q;

endmodule
